// File: rtl/clb_cfg_loader.sv
// rtl/clb_cfg_loader.sv - serial preamble-synced, parity-checked loader for the CLB configuration word
module clb_cfg_loader #(
    parameter int                  CFG_BITS  = 37,
    parameter int                  PRE_BITS  = 8,
    parameter logic [PRE_BITS-1:0] PREAMBLE  = 8'hF2,
    parameter logic [CFG_BITS-1:0] CFG_RESET = 37'h15_0008_B038
) (
    input  logic                K,
    input  logic                RESETN,
    input  logic                DIN,
    input  logic                DIN_VALID,
    input  logic                PROG,
    output logic [CFG_BITS-1:0] CFG,
    output logic                CFG_LOAD,
    output logic                BUSY,
    output logic                DONE,
    output logic                ERR
);

    localparam int CNT_W = $clog2(CFG_BITS + 1);

    typedef enum logic [1:0] {HUNT, LOAD, CHECK} state_t;

    state_t              state;
    state_t              state_nx;
    logic [PRE_BITS-2:0] window;
    logic [PRE_BITS-1:0] win_nx;
    logic [CFG_BITS-1:0] shadow;
    logic [CNT_W-1:0]    cnt;
    logic                accept;
    logic                detect;
    logic                payload_last;
    logic                parity_bit;
    logic                parity_ok;

    always_ff @(posedge K or negedge RESETN) begin
        if (!RESETN) begin
            state <= HUNT;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (PROG) begin
            state_nx = HUNT;
        end else begin
            case (state)
                HUNT:    if (detect)       state_nx = LOAD;
                LOAD:    if (payload_last) state_nx = CHECK;
                CHECK:   if (accept)       state_nx = HUNT;
                default:                   state_nx = HUNT;
            endcase
        end
    end

    // Only the newest PRE_BITS-1 bits are kept; the incoming bit completes the compare window.
    always_comb begin
        accept       = DIN_VALID && !PROG;
        win_nx       = {window, DIN};
        detect       = (state == HUNT) && accept && (win_nx == PREAMBLE);
        payload_last = (state == LOAD) && accept && (cnt == CNT_W'(CFG_BITS - 1));
        parity_bit   = (state == CHECK) && accept;
        parity_ok    = !(^{shadow, DIN});
    end

    always_ff @(posedge K or negedge RESETN) begin
        if (!RESETN) begin
            window   <= '0;
            shadow   <= '0;
            cnt      <= '0;
            CFG      <= CFG_RESET;
            CFG_LOAD <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            ERR      <= 1'b0;
        end else begin
            CFG_LOAD <= 1'b0;
            if (PROG) begin
                window <= '0;
                BUSY   <= 1'b0;
                DONE   <= 1'b0;
                ERR    <= 1'b0;
            end else if (accept) begin
                if (state == HUNT) begin
                    window <= win_nx[PRE_BITS-2:0];
                end
                if (detect) begin
                    BUSY <= 1'b1;
                    DONE <= 1'b0;
                    ERR  <= 1'b0;
                    cnt  <= '0;
                end
                if (state == LOAD) begin
                    shadow <= {shadow[CFG_BITS-2:0], DIN};
                    cnt    <= cnt + CNT_W'(1);
                end
                if (parity_bit) begin
                    window <= '0;
                    BUSY   <= 1'b0;
                    if (parity_ok) begin
                        CFG      <= shadow;
                        CFG_LOAD <= 1'b1;
                        DONE     <= 1'b1;
                    end else begin
                        ERR <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_clb_cfg_loader.sv
// tb/tb_clb_cfg_loader.sv - directed table-driven bench for clb_cfg_loader
module tb_clb_cfg_loader;

    localparam logic [36:0] CFG_RESET = 37'h15_0008_B038;

    logic        K;
    logic        RESETN;
    logic        DIN;
    logic        DIN_VALID;
    logic        PROG;
    logic [36:0] CFG;
    logic        CFG_LOAD;
    logic        BUSY;
    logic        DONE;
    logic        ERR;

    int total = 0;
    int bad   = 0;
    int loads = 0;

    typedef struct {
        string       name;
        logic [36:0] payload;
        logic        parity;
        bit          gapped;
        logic [36:0] exp_cfg;
        logic        exp_done;
        logic        exp_err;
        int          exp_loads;
    } frame_vec_t;

    frame_vec_t vecs[3];

    clb_cfg_loader dut (
        .K         (K),
        .RESETN    (RESETN),
        .DIN       (DIN),
        .DIN_VALID (DIN_VALID),
        .PROG      (PROG),
        .CFG       (CFG),
        .CFG_LOAD  (CFG_LOAD),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .ERR       (ERR)
    );

    initial begin
        K = 1'b0;
        forever #5 K = ~K;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step(input logic b, input logic v, input logic p);
        @(negedge K);
        DIN       = b;
        DIN_VALID = v;
        PROG      = p;
        @(posedge K);
        #1;
        if (CFG_LOAD === 1'b1) loads++;
    endtask

    task automatic send_bits(input logic [63:0] val, input int n, input bit gap);
        for (int i = n - 1; i >= 0; i--) begin
            step(val[i], 1'b1, 1'b0);
            if (gap) step(1'($urandom), 1'b0, 1'b0);
        end
    endtask

    task automatic send_preamble(input string name, input bit gap);
        send_bits(64'h79, 7, gap);
        check({name, " busy_before_last_pre_bit"}, BUSY, 1'b0);
        send_bits(64'h0, 1, gap);
        check({name, " busy_on_detect"}, BUSY, 1'b1);
        check({name, " done_cleared"}, DONE, 1'b0);
        check({name, " err_cleared"}, ERR, 1'b0);
    endtask

    task automatic run_frame(input frame_vec_t v);
        loads = 0;
        if (v.gapped) send_bits(64'hFF, 8, 1'b1);
        send_preamble(v.name, v.gapped);
        send_bits({27'd0, v.payload}, 37, v.gapped);
        check({v.name, " busy_before_parity"}, BUSY, 1'b1);
        step(v.parity, 1'b1, 1'b0);
        check({v.name, " cfg_load_on_parity_edge"}, CFG_LOAD, v.exp_loads != 0);
        check({v.name, " cfg"}, CFG, v.exp_cfg);
        check({v.name, " done"}, DONE, v.exp_done);
        check({v.name, " err"}, ERR, v.exp_err);
        check({v.name, " busy_after"}, BUSY, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check({v.name, " cfg_load_dropped"}, CFG_LOAD, 1'b0);
        check({v.name, " load_pulses"}, loads, v.exp_loads);
    endtask

    initial begin
        int devs;
        frame_vec_t f;

        vecs[0] = '{"good",   37'h1F_FFFF_FFFF, 1'b1, 1'b0, 37'h1F_FFFF_FFFF, 1'b1, 1'b0, 1};
        vecs[1] = '{"badpar", 37'h00_0000_0001, 1'b0, 1'b0, 37'h1F_FFFF_FFFF, 1'b0, 1'b1, 0};
        vecs[2] = '{"gapped", 37'h00_0001_0000, 1'b1, 1'b1, 37'h00_0001_0000, 1'b1, 1'b0, 1};

        RESETN    = 1'b0;
        DIN       = 1'b0;
        DIN_VALID = 1'b0;
        PROG      = 1'b0;
        repeat (3) @(negedge K);
        check("reset cfg", CFG, CFG_RESET);
        check("reset cfg_load", CFG_LOAD, 1'b0);
        check("reset busy", BUSY, 1'b0);
        check("reset done", DONE, 1'b0);
        check("reset err", ERR, 1'b0);
        RESETN = 1'b1;

        devs  = 0;
        loads = 0;
        for (int i = 0; i < 100; i++) begin
            step(1'($urandom), 1'b0, 1'b0);
            if (CFG !== CFG_RESET || BUSY !== 1'b0 || DONE !== 1'b0 || ERR !== 1'b0) devs++;
        end
        check("idle hold deviations", devs, 0);
        check("idle no load", loads, 0);

        foreach (vecs[i]) run_frame(vecs[i]);

        send_preamble("abort", 1'b0);
        send_bits(64'hA_BCDE, 20, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        check("abort busy", BUSY, 1'b0);
        check("abort done", DONE, 1'b0);
        check("abort err", ERR, 1'b0);
        check("abort cfg kept", CFG, 37'h00_0001_0000);
        check("abort no load", CFG_LOAD, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        f = '{"after_abort", 37'h0A_5A5A_5A5A, 1'b0, 1'b0, 37'h0A_5A5A_5A5A, 1'b1, 1'b0, 1};
        run_frame(f);

        send_preamble("areset", 1'b0);
        send_bits(64'h2AB, 10, 1'b0);
        @(negedge K);
        #2 RESETN = 1'b0;
        #1;
        check("areset cfg", CFG, CFG_RESET);
        check("areset busy", BUSY, 1'b0);
        check("areset done", DONE, 1'b0);
        check("areset err", ERR, 1'b0);
        @(negedge K);
        RESETN = 1'b1;
        f = '{"after_areset", 37'h1F_FFFF_FFFF, 1'b1, 1'b0, 37'h1F_FFFF_FFFF, 1'b1, 1'b0, 1};
        run_frame(f);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clb_cfg_loader.md
Name: clb_cfg_loader

Overview:
- Serial configuration loader that sits directly upstream of the logic-block (CLB) cell.
- Hunts a bit-serial stream for a preamble, then shifts in one CLB configuration frame and checks its even parity.
- On a good frame it atomically updates the parallel configuration word that drives the CLB's LUT contents (mem), mux selects, combinational option, DQ muxes and flop/latch bit.
- Replaces the hard-coded initial configuration with a loadable one.

Parameters:
- CFG_BITS, 37, payload width.
- PRE_BITS, 8, preamble width.
- PREAMBLE, 8'hF2, sync pattern, MSB first.
- CFG_RESET, 37'h15_0008_B038, CFG value after reset, equal to the CLB power-on configuration.

Ports:
- K  input  1  clock; all logic on posedge.
- RESETN  input  1  asynchronous active-low reset.
- DIN  input  1  serial config data.
- DIN_VALID  input  1  qualifies DIN for one cycle.
- PROG  input  1  synchronous abort/restart.
- CFG  output  CFG_BITS  configuration word to the CLB.
- CFG_LOAD  output  1  one-cycle pulse when CFG updates.
- BUSY  output  1  frame in progress.
- DONE  output  1  last frame loaded OK.
- ERR  output  1  last frame failed parity.

Behaviour:
- Reset and clock: one clock K; reset RESETN is asynchronous, active-low.
  - Reset state: FSM=HUNT, preamble window=0, shadow=0, bit counter=0.
  - Reset outputs: CFG=CFG_RESET, CFG_LOAD=0, BUSY=0, DONE=0, ERR=0.
- CFG packing, MSB first:
  - [36:35] mux2select, [34:33] mux3select, [32:31] mux4select, [30:29] mux5select, [28:27] mux6select.
  - [26:11] mem[15:0].
  - [10:9] comboption.
  - [8] o2m1_0, [7] o2m2_0, [6] o2m3_0, [5] o2m1_1, [4] o2m2_1, [3] o2m3_1.
  - [2] DQmux1, [1] DQmux2, [0] floporlatch.
- Bit acceptance: a bit is consumed only on a cycle with DIN_VALID=1. Cycles with DIN_VALID=0 change no state except via PROG.
- FSM:
  - HUNT: shift DIN into the PRE_BITS window (newest bit at LSB). When the updated window equals PREAMBLE, go to LOAD on the same edge: clear DONE and ERR, set BUSY, clear the counter. Overlapping patterns are detected.
  - LOAD: shift DIN into the shadow register at LSB and increment the counter. After CFG_BITS accepted bits, go to CHECK. The first payload bit lands in shadow[CFG_BITS-1].
  - CHECK: next accepted bit is the parity bit. Pass when XOR(shadow, parity bit)=0.
    - Pass: CFG<=shadow, CFG_LOAD=1 for exactly one cycle, DONE=1.
    - Fail: CFG unchanged, ERR=1.
    - Either way: BUSY=0, return to HUNT with the window cleared.
- Latency: CFG and CFG_LOAD update on the clock edge that accepts the parity bit.
- DONE and ERR are sticky until the next preamble detect, PROG, or reset. They are never both 1.
- PROG=1:
  - FSM goes to HUNT, window cleared, BUSY/DONE/ERR=0, CFG retained.
  - PROG has priority over a simultaneous DIN_VALID; that bit is discarded.
- Reset mid-frame: returns to CFG_RESET; the partially shifted frame is lost.
- Window in LOAD/CHECK: payload bits never trigger preamble detection. The window is not updated outside HUNT.
- Counter width: clog2(CFG_BITS+1). No wrap is possible; the counter clears on entering LOAD.
- Back-to-back frames: a new preamble may start on the cycle after the parity bit.
- CFG is a registered output only, no combinational path from DIN, so the CLB sees a glitch-free word.

Test Plan:
- Reset with RESETN=0, then release -> CFG=37'h15_0008_B038, DONE=ERR=BUSY=CFG_LOAD=0; output holds for 100 cycles of random DIN with DIN_VALID=0.
- Good frame: send 0xF2, payload 37'h1F_FFFF_FFFF, parity 1 -> BUSY high from the preamble edge; CFG=37'h1F_FFFF_FFFF, DONE=1, CFG_LOAD a single pulse on the parity edge.
- Bad parity: after the good frame, send 0xF2, payload 37'h00_0000_0001, parity 0 -> ERR=1, DONE=0, CFG stays 37'h1F_FFFF_FFFF, no CFG_LOAD.
- Gapped and overlapping preamble: send 0xFF then 0xF2 with DIN_VALID toggling 1/0 every cycle, payload 37'h00_0001_0000, parity 1 -> detection on the correct bit; CFG=37'h00_0001_0000.
- Abort: assert PROG after 20 payload bits (DIN_VALID=1 on the same cycle), then send a full good frame with payload 37'h0A_5A5A_5A5A, parity 0 -> BUSY drops on the PROG edge, CFG unchanged until the new frame, then CFG=37'h0A_5A5A_5A5A.
- Async reset mid-LOAD: drive RESETN low between clock edges -> outputs go to reset values immediately without a clock edge; the next good frame loads normally.
